// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared definitions for the iterative M-extension multiply/divide unit:
// op bit indices of the one-hot select, FSM state encoding, fixed latency,
// iteration bound and the quotient returned on a zero divisor.
package muldiv_unit_pkg;

  localparam int MD_XLEN = 32;
  localparam int OP_W    = 8;

  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHSU = 2;
  localparam int OP_MULHU  = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;

  // Cycles from the accepting edge to the cycle in which done is high.
  localparam int LATENCY = 34;

  // Counter value on the last of the 32 CALC iterations.
  localparam logic [5:0] ITER_LAST = 6'd31;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True when exactly one op select bit is set.
  function automatic logic is_onehot(input logic [OP_W-1:0] v);
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Request/response bundle between the issue stage and the multiply/divide unit.
//   start, op, rs1_val, rs2_val, rd_in, flush : request side (master drives)
//   busy, done, result, rd_out                : response side (slave drives)
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic               start;
  logic [OP_W-1:0]    op;
  logic [MD_XLEN-1:0] rs1_val;
  logic [MD_XLEN-1:0] rs2_val;
  logic [4:0]         rd_in;
  logic               flush;
  logic               busy;
  logic               done;
  logic [MD_XLEN-1:0] result;
  logic [4:0]         rd_out;

  modport master (
    output start, op, rs1_val, rs2_val, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_in, flush,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational iteration on magnitudes, operating on a {hi, lo} pair.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi, lo  : multiply: partial product high half / remaining multiplier bits
//             divide:   partial remainder / dividend bits becoming quotient bits
//   m       : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   hi_next, lo_next : pair after this iteration
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] m,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;

  // The partial remainder always stays below the divisor, so the W+1 bit
  // difference has its top bit set exactly when the trial subtract borrows.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[W-1]};
    diff    = shifted - {1'b0, m};
    if (is_div) begin
      hi_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
      lo_next = {lo[W-2:0], ~diff[W]};
    end else begin
      hi_next = sum[W:1];
      lo_next = {sum[0], lo[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32 M-extension unit: 32 CALC iterations, one FIX cycle for sign
// correction, then a one-cycle DONE pulse; fixed latency for every op.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request/response bundle (slave side)
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  state_t            state, state_next;
  logic [5:0]        count;
  logic [XLEN-1:0]   hi, lo, m;
  logic [XLEN-1:0]   hi_step, lo_step;
  logic [XLEN-1:0]   result_q;
  logic [OP_W-1:0]   op_q;
  logic [4:0]        rd_q;
  logic              neg_a, neg_b, b_zero;

  logic              accept;
  logic              in_div, in_signed_a, in_signed_b, in_neg_a, in_neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quo_fixed, rem_fixed, fix_value;
  logic              busy_c, done_c;
  logic [XLEN-1:0]   result_c;
  logic [4:0]        rd_c;

  assign accept = (state == ST_IDLE) && bus.start && !bus.flush && is_onehot(bus.op);

  // Decode signedness of the incoming request and take operand magnitudes.
  // mul is treated as signed*signed; its low half is identical either way.
  always_comb begin
    in_div      = |bus.op[OP_REMU:OP_DIV];
    in_signed_a = bus.op[OP_MUL] | bus.op[OP_MULH] | bus.op[OP_MULHSU] |
                  bus.op[OP_DIV] | bus.op[OP_REM];
    in_signed_b = bus.op[OP_MUL] | bus.op[OP_MULH] | bus.op[OP_DIV] | bus.op[OP_REM];
    in_neg_a    = in_signed_a & bus.rs1_val[XLEN-1];
    in_neg_b    = in_signed_b & bus.rs2_val[XLEN-1];
    mag_a       = in_neg_a ? -bus.rs1_val : bus.rs1_val;
    mag_b       = in_neg_b ? -bus.rs2_val : bus.rs2_val;
  end

  muldiv_step #(.W(XLEN)) u_step (
    .is_div  (|op_q[OP_REMU:OP_DIV]),
    .hi      (hi),
    .lo      (lo),
    .m       (m),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush aborts only while the work is still in progress.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_CALC;
      ST_CALC: begin
        if (bus.flush)               state_next = ST_IDLE;
        else if (count == ITER_LAST) state_next = ST_FIX;
      end
      ST_FIX:  state_next = bus.flush ? ST_IDLE : ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and result latching. Multiply keeps the
  // multiplier in lo; divide keeps the dividend there so quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      b_zero   <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      count  <= '0;
      hi     <= '0;
      lo     <= in_div ? mag_a : mag_b;
      m      <= in_div ? mag_b : mag_a;
      op_q   <= bus.op;
      rd_q   <= bus.rd_in;
      neg_a  <= in_neg_a;
      neg_b  <= in_neg_b;
      b_zero <= (bus.rs2_val == '0);
    end else if (state == ST_CALC) begin
      hi    <= hi_step;
      lo    <= lo_step;
      count <= count + 6'd1;
    end else if (state == ST_FIX) begin
      result_q <= fix_value;
    end
  end

  // Sign fixup. A zero divisor needs an explicit quotient override; the
  // remainder path already yields rs1_val, and signed overflow falls out of
  // the two's-complement negation naturally.
  always_comb begin
    prod_fixed = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
    quo_fixed  = b_zero ? DIV_ZERO_Q : ((neg_a ^ neg_b) ? -lo : lo);
    rem_fixed  = neg_a ? -hi : hi;
    if (op_q[OP_MUL])
      fix_value = prod_fixed[XLEN-1:0];
    else if (op_q[OP_MULH] | op_q[OP_MULHSU] | op_q[OP_MULHU])
      fix_value = prod_fixed[2*XLEN-1:XLEN];
    else if (op_q[OP_DIV] | op_q[OP_DIVU])
      fix_value = quo_fixed;
    else
      fix_value = rem_fixed;
  end

  // Outputs depend on state only, so reset clears them immediately.
  always_comb begin
    busy_c   = (state != ST_IDLE);
    done_c   = (state == ST_DONE);
    result_c = done_c ? result_q : '0;
    rd_c     = done_c ? rd_q : '0;
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_c;
  assign bus.rd_out = rd_c;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench: an arithmetic reference model plus a latency-count
// model are compared against the unit every cycle, alongside directed cases
// with literal expected values and a randomized phase.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model state: cycles elapsed since the accepting edge (0 = nothing in flight).
  int          age = 0;
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_rd = '0;
  logic [38:0] exp_vec;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // RISC-V M-extension results from plain integer arithmetic.
  function automatic logic [31:0] ref_calc(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (op)
      8'h01: begin p = sa * sb; return p[31:0]; end
      8'h02: begin p = sa * sb; return p[63:32]; end
      8'h04: begin p = sa * ub; return p[63:32]; end
      8'h08: begin p = ua * ub; return p[63:32]; end
      8'h10: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      8'h20: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      8'h40: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      8'h80: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural latency model: accept only when idle with a one-hot op and no
  // flush; flush aborts before the done cycle; the done cycle always ends it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= 0;
    end else if (age == 0) begin
      if (bus.start && !bus.flush && $countones(bus.op) == 1) begin
        age        <= 1;
        exp_result <= ref_calc(bus.op, bus.rs1_val, bus.rs2_val);
        exp_rd     <= bus.rd_in;
      end
    end else if (age == LATENCY) begin
      age <= 0;
    end else if (bus.flush) begin
      age <= 0;
    end else begin
      age <= age + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_vec = {age != 0, age == LATENCY,
                 (age == LATENCY) ? exp_result : 32'h0,
                 (age == LATENCY) ? exp_rd : 5'h0};
      checkOutput("cycle outputs", {bus.busy, bus.done, bus.result, bus.rd_out}, exp_vec);
    end
  end

  // Issue one request at a negedge and wait for its done pulse. In noisy mode,
  // stray starts arrive while busy and flush is raised during the done cycle.
  task automatic applyStimulus(input string name, input logic [7:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] expv, input bit noisy);
    int n;
    bit seen;
    bus.start = 1'b1; bus.op = op; bus.rs1_val = a; bus.rs2_val = b; bus.rd_in = rd;
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (noisy && n == 5) begin
        bus.start = 1'b1; bus.op = 8'h20; bus.rs1_val = 32'h1234; bus.rs2_val = 32'd3;
        bus.rd_in = 5'd31;
      end
      if (noisy && n == 8) begin
        bus.start = 1'b1; bus.op = 8'h03; bus.rd_in = 5'd30;
      end
      if (bus.done) begin
        seen = 1'b1;
        checkOutput({name, " latency"}, 64'(n), 64'(LATENCY));
        checkOutput({name, " result"}, {32'h0, bus.result}, {32'h0, expv});
        checkOutput({name, " rd_out"}, {59'h0, bus.rd_out}, {59'h0, rd});
        if (noisy) bus.flush = 1'b1;
      end
    end
    checkOutput({name, " done seen"}, {63'h0, seen}, 64'd1);
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] rand_op();
    if ($urandom_range(0, 9) < 8) return 8'(1 << $urandom_range(0, 7));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int n;
    int guard;
    bit any_done;
    bus.start = 1'b0; bus.op = '0; bus.rs1_val = '0; bus.rs2_val = '0;
    bus.rd_in = '0; bus.flush = 1'b0;

    // Pin the reference model with hand-computed values.
    checkOutput("model mul", {32'h0, ref_calc(8'h01, 32'd7, 32'hFFFF_FFFD)}, 64'hFFFF_FFEB);
    checkOutput("model mulhsu", {32'h0, ref_calc(8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFF);
    checkOutput("model rem", {32'h0, ref_calc(8'h40, 32'hFFFF_FFF9, 32'd2)}, 64'hFFFF_FFFF);
    checkOutput("model div ovf", {32'h0, ref_calc(8'h10, 32'h8000_0000, 32'hFFFF_FFFF)}, 64'h8000_0000);

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset outputs", {25'h0, bus.busy, bus.done, bus.result, bus.rd_out}, 64'h0);
    rst_n = 1'b1;

    $display("[TB] directed multiply cases");
    applyStimulus("mul 7*-3", 8'h01, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1'b0);
    applyStimulus("mulh -1*-1", 8'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 1'b0);
    applyStimulus("mulhsu -1*max", 8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("mulhu max*max", 8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b0);

    $display("[TB] directed divide cases");
    applyStimulus("div -7/2", 8'h10, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b0);
    applyStimulus("rem -7/2", 8'h40, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("divu 100/0", 8'h20, 32'd100, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("remu 100/0", 8'h80, 32'd100, 32'd0, 5'd8, 32'd100, 1'b0);
    applyStimulus("div ovf", 8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1'b0);
    applyStimulus("rem ovf", 8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 1'b0);
    applyStimulus("div -5/0", 8'h10, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("rem -5/0", 8'h40, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, 1'b0);

    $display("[TB] ignored requests");
    applyStimulus("mul noisy", 8'h01, 32'd1000, 32'd1000, 5'd13, 32'h000F_4240, 1'b1);
    applyStimulus("divu noisy", 8'h20, 32'h1234_5678, 32'h10, 5'd14, 32'h0123_4567, 1'b1);
    bus.start = 1'b1; bus.op = 8'h03;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("idle op 0x03 busy", {63'h0, bus.busy}, 64'd0);
    bus.start = 1'b1; bus.op = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("idle op 0x00 busy", {63'h0, bus.busy}, 64'd0);

    $display("[TB] flush mid-divide");
    bus.start = 1'b1; bus.op = 8'h10; bus.rs1_val = 32'd1000; bus.rs2_val = 32'd7;
    bus.rd_in = 5'd15;
    for (n = 1; n <= 11; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n == 10) bus.flush = 1'b1;
    end
    checkOutput("flush busy at cycle 11", {63'h0, bus.busy}, 64'd0);
    bus.flush = 1'b0;
    any_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      any_done |= bus.done;
    end
    checkOutput("flush no done", {63'h0, any_done}, 64'd0);
    applyStimulus("mul after flush", 8'h01, 32'd6, 32'd7, 5'd16, 32'd42, 1'b0);

    $display("[TB] async reset mid-calc");
    bus.start = 1'b1; bus.op = 8'h20; bus.rs1_val = 32'd999; bus.rs2_val = 32'd3;
    bus.rd_in = 5'd17;
    repeat (12) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset outputs", {25'h0, bus.busy, bus.done, bus.result, bus.rd_out}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("mul after reset", 8'h01, 32'hFFFF_FFFF, 32'd5, 5'd18, 32'hFFFF_FFFB, 1'b0);

    $display("[TB] randomized phase");
    for (int t = 0; t < 150; t++) begin
      bus.op = rand_op(); bus.rs1_val = rand_val(); bus.rs2_val = rand_val();
      bus.rd_in = 5'($urandom_range(0, 31)); bus.flush = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      guard = 0;
      while (age != 0 && guard < 60) begin
        bus.start = ($urandom_range(0, 15) == 0);
        bus.op = rand_op(); bus.rs1_val = rand_val(); bus.rs2_val = rand_val();
        bus.rd_in = 5'($urandom_range(0, 31));
        bus.flush = ($urandom_range(0, 63) == 0);
        @(negedge clk);
        guard++;
      end
      checkOutput("random settle", {63'h0, guard < 60}, 64'd1);
      bus.start = 1'b0;
      bus.flush = 1'b0;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
